// File: rtl/ife_block_dispatcher.sv
// IFE block dispatcher: pops blocks from the block queue, picks a free core
// round-robin, and streams the block's instrs to it one beat per handshake.
// Ports: clk, rst_n (async active-low)
//   queue side: block_id_in, block_in, valid_in, ready_out
//   core side : core_instr, core_block_id, core_valid, core_last,
//               core_ready, core_done, busy_mask
//   IFE_DISPATCH_STATS_EN adds dispatch_count, stall_count
module ife_block_dispatcher #(
  parameter int BLOCK_ID_WIDTH = 8,
  parameter int INSTR_WIDTH    = 32,
  parameter int BLOCK_SIZE     = 4,
  parameter int NUM_CORES      = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [BLOCK_ID_WIDTH-1:0]         block_id_in,
  input  logic [BLOCK_SIZE*INSTR_WIDTH-1:0] block_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [NUM_CORES*INSTR_WIDTH-1:0]  core_instr,
  output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] core_block_id,
  output logic [NUM_CORES-1:0]              core_valid,
  output logic [NUM_CORES-1:0]              core_last,
  input  logic [NUM_CORES-1:0]              core_ready,
  input  logic [NUM_CORES-1:0]              core_done,
  output logic [NUM_CORES-1:0]              busy_mask
`ifdef IFE_DISPATCH_STATS_EN
  ,
  output logic [15:0]                       dispatch_count,
  output logic [15:0]                       stall_count
`endif
);

  localparam int CW = $clog2(NUM_CORES);
  localparam int BW = $clog2(BLOCK_SIZE);
  localparam int IW = INSTR_WIDTH;
  localparam int DW = BLOCK_ID_WIDTH;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                       state_q, state_d;
  logic [NUM_CORES-1:0]         busy_q, busy_d, clr;
  logic [CW-1:0]                rr_q, rr_d;
  logic [CW-1:0]                tgt_q, tgt_d;
  logic [CW-1:0]                pick, idx;
  logic                         found;
  logic [BW-1:0]                beat_q, beat_d;
  logic [DW-1:0]                id_q, id_d;
  logic [BLOCK_SIZE*IW-1:0]     buf_q, buf_d;
  logic                         take, acc, last;

  assign busy_mask = busy_q;
  assign ready_out = (state_q == IDLE) && !(&busy_q);
  assign take      = valid_in && ready_out;
  assign acc       = (state_q == ISSUE) && core_ready[tgt_q];
  assign last      = (beat_q == BW'(BLOCK_SIZE-1));

  // first free core scanning from rr_q upward, wrapping
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = CW'((int'(rr_q) + k) % NUM_CORES);
      if (!found && !busy_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    beat_d  = beat_q;
    id_d    = id_q;
    buf_d   = buf_q;
    // done on the core being issued to is a protocol error: keep busy
    clr     = core_done & busy_q;
    if (state_q == ISSUE) clr[tgt_q] = 1'b0;
    busy_d  = busy_q & ~clr;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          id_d         = block_id_in;
          buf_d        = block_in;
          tgt_d        = pick;
          busy_d[pick] = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (acc) begin
          if (last) begin
            beat_d  = '0;
            rr_d    = (tgt_q == CW'(NUM_CORES-1)) ? '0 : tgt_q + 1'b1;
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_valid    = '0;
    core_last     = '0;
    core_instr    = '0;
    core_block_id = '0;
    if (state_q == ISSUE) begin
      core_valid[tgt_q] = 1'b1;
      core_last[tgt_q]  = last;
      core_instr[int'(tgt_q)*IW +: IW] =
        buf_q[int'(beat_q)*IW +: IW];
      core_block_id[int'(tgt_q)*DW +: DW] = id_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= '0;
      rr_q    <= '0;
      tgt_q   <= '0;
      beat_q  <= '0;
      id_q    <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
      beat_q  <= beat_d;
      id_q    <= id_d;
      buf_q   <= buf_d;
    end
  end

`ifdef IFE_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispatch_count <= '0;
      stall_count    <= '0;
    end else begin
      if (acc && last)
        dispatch_count <= dispatch_count + 16'd1;
      if (state_q == ISSUE && !core_ready[tgt_q] &&
          stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
